// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue path: unit codes, dispatch FSM states,
// and the default set of multi-cycle units.
package alu_pkg;

    // Codes 0 and 1 are the 64-bit multi-cycle units; 2..7 are single-cycle 32-bit units
    localparam logic [2:0] UNIT_MUL  = 3'd0;
    localparam logic [2:0] UNIT_DIV  = 3'd1;
    localparam logic [2:0] UNIT_ADD  = 3'd2;
    localparam logic [2:0] UNIT_SUB  = 3'd3;
    localparam logic [2:0] UNIT_AND  = 3'd4;
    localparam logic [2:0] UNIT_OR   = 3'd5;
    localparam logic [2:0] UNIT_XOR  = 3'd6;
    localparam logic [2:0] UNIT_SHF  = 3'd7;

    localparam logic [7:0] MULTI_MASK_DEF = 8'b0000_0011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/alu_dispatch_timeout.sv
// Clearable BUSY-cycle counter; term_o flags the final allowed cycle
// so the FSM can leave BUSY on that edge.
module alu_dispatch_timeout #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic term_o
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear wins over increment
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = {CNT_W{1'b0}};
        end else if (en_i) begin
            count_d = count_q + CNT_W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= {CNT_W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign term_o = (count_q == LAST);

endmodule

// File: rtl/alu_dispatch.sv
// Issue-side controller: accepts one op, broadcasts operands, pulses the unit
// start, waits for completion or timeout, and holds the result-mux select.
module alu_dispatch
    import alu_pkg::*;
#(
    parameter int         DATA_W     = 32,
    parameter logic [7:0] MULTI_MASK = MULTI_MASK_DEF,
    parameter int         TIMEOUT    = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    output logic [DATA_W-1:0] unit_a,
    output logic [DATA_W-1:0] unit_b,
    output logic [7:0]        unit_start,
    input  logic [7:0]        unit_done,
    output logic [2:0]        mux_sel,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_err
);

    state_e            state_q, state_d;
    logic [2:0]        mux_sel_q, mux_sel_d;
    logic [DATA_W-1:0] unit_a_q, unit_a_d;
    logic [DATA_W-1:0] unit_b_q, unit_b_d;
    logic [7:0]        unit_start_q, unit_start_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic              tmo_clr_s, tmo_en_s, tmo_term_s;
    logic              done_s, multi_s;

    // mux_sel_q doubles as the op register: it only changes on accept
    assign done_s  = unit_done[mux_sel_q];
    assign multi_s = MULTI_MASK[mux_sel_q];

    // Next-state and next-output decode
    always_comb begin
        state_d      = state_q;
        mux_sel_d    = mux_sel_q;
        unit_a_d     = unit_a_q;
        unit_b_d     = unit_b_q;
        unit_start_d = 8'b0000_0000;
        rsp_valid_d  = rsp_valid_q;
        rsp_err_d    = rsp_err_q;
        tmo_clr_s    = 1'b0;
        tmo_en_s     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    state_d      = S_BUSY;
                    mux_sel_d    = req_op;
                    unit_a_d     = req_a;
                    unit_b_d     = req_b;
                    unit_start_d = 8'b0000_0001 << req_op;
                    tmo_clr_s    = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                tmo_en_s = 1'b1;
                // Done is checked before the timeout so a same-cycle done wins
                if (!multi_s || done_s) begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                end else if (tmo_term_s) begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end else begin
                    state_d = S_BUSY;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                end else begin
                    state_d = S_RESP;
                end
            end
            default: begin
                state_d     = S_IDLE;
                rsp_valid_d = 1'b0;
                rsp_err_d   = 1'b0;
            end
        endcase
    end

    // FSM state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            mux_sel_q    <= 3'd0;
            unit_a_q     <= {DATA_W{1'b0}};
            unit_b_q     <= {DATA_W{1'b0}};
            unit_start_q <= 8'b0000_0000;
            rsp_valid_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            mux_sel_q    <= mux_sel_d;
            unit_a_q     <= unit_a_d;
            unit_b_q     <= unit_b_d;
            unit_start_q <= unit_start_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    alu_dispatch_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (tmo_clr_s),
        .en_i   (tmo_en_s),
        .term_o (tmo_term_s)
    );

    assign req_ready  = (state_q == S_IDLE);
    assign mux_sel    = mux_sel_q;
    assign unit_a     = unit_a_q;
    assign unit_b     = unit_b_q;
    assign unit_start = unit_start_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_dispatch.sv
// Directed bench for alu_dispatch: table of single-cycle ops plus hand-written
// multi-cycle, timeout, backpressure and reset sequences.
module tb_alu_dispatch;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [31:0] unit_a;
    logic [31:0] unit_b;
    logic [7:0]  unit_start;
    logic [7:0]  unit_done;
    logic [2:0]  mux_sel;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_err;

    int n_total = 0;
    int n_pass  = 0;

    alu_dispatch #(
        .DATA_W     (32),
        .MULTI_MASK (8'b0000_0011),
        .TIMEOUT    (64)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .unit_a     (unit_a),
        .unit_b     (unit_b),
        .unit_start (unit_start),
        .unit_done  (unit_done),
        .mux_sel    (mux_sel),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_err    (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [7:0]  exp_start;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one cycle; return at the following falling edge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Present a request at a falling edge and let the next rising edge accept it
    task automatic accept(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        check("ready_before_accept", 64'(req_ready), 64'd1);
        step();
        req_valid = 1'b0;
    endtask

    initial begin
        logic seen_bad;

        vecs[0] = '{op: 3'd3, a: 32'h0000_0010, b: 32'h0000_0020, exp_start: 8'b0000_1000};
        vecs[1] = '{op: 3'd2, a: 32'hFFFF_FFFF, b: 32'h0000_0001, exp_start: 8'b0000_0100};
        vecs[2] = '{op: 3'd7, a: 32'hA5A5_A5A5, b: 32'h5A5A_5A5A, exp_start: 8'b1000_0000};
        vecs[3] = '{op: 3'd4, a: 32'h0000_0000, b: 32'hDEAD_BEEF, exp_start: 8'b0001_0000};
        vecs[4] = '{op: 3'd5, a: 32'h1234_5678, b: 32'h0000_0000, exp_start: 8'b0010_0000};
        vecs[5] = '{op: 3'd6, a: 32'h8000_0000, b: 32'h7FFF_FFFF, exp_start: 8'b0100_0000};

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_op    = 3'd0;
        req_a     = 32'd0;
        req_b     = 32'd0;
        unit_done = 8'd0;
        rsp_ready = 1'b1;

        // Reset state
        #12;
        check("rst_req_ready",  64'(req_ready),  64'd1);
        check("rst_mux_sel",    64'(mux_sel),    64'd0);
        check("rst_unit_a",     64'(unit_a),     64'd0);
        check("rst_unit_b",     64'(unit_b),     64'd0);
        check("rst_rsp_valid",  64'(rsp_valid),  64'd0);
        check("rst_rsp_err",    64'(rsp_err),    64'd0);
        check("rst_unit_start", 64'(unit_start), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Single-cycle ops: start pulse in cycle 1, response in cycle 2 only
        for (int i = 0; i < 6; i++) begin
            accept(vecs[i].op, vecs[i].a, vecs[i].b);
            check("sc_start_c1",  64'(unit_start), 64'(vecs[i].exp_start));
            check("sc_mux_sel",   64'(mux_sel),    64'(vecs[i].op));
            check("sc_unit_a",    64'(unit_a),     64'(vecs[i].a));
            check("sc_unit_b",    64'(unit_b),     64'(vecs[i].b));
            check("sc_valid_c1",  64'(rsp_valid),  64'd0);
            check("sc_ready_c1",  64'(req_ready),  64'd0);
            step();
            check("sc_valid_c2",  64'(rsp_valid),  64'd1);
            check("sc_err_c2",    64'(rsp_err),    64'd0);
            check("sc_start_c2",  64'(unit_start), 64'd0);
            step();
            check("sc_valid_c3",  64'(rsp_valid),  64'd0);
            check("sc_ready_c3",  64'(req_ready),  64'd1);
            check("sc_sel_hold",  64'(mux_sel),    64'(vecs[i].op));
        end

        // Multi-cycle op 0: stray done[1] in cycle 2, done[0] in cycle 5
        accept(3'd0, 32'hCAFE_0001, 32'hBEEF_0002);
        check("mc_start_c1", 64'(unit_start), 64'h01);
        seen_bad = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            unit_done = (c == 2) ? 8'b0000_0010 : ((c == 5) ? 8'b0000_0001 : 8'b0000_0000);
            if (rsp_valid !== 1'b0 || unit_a !== 32'hCAFE_0001 || unit_b !== 32'hBEEF_0002) begin
                seen_bad = 1'b1;
            end
            if (c > 1 && unit_start !== 8'd0) begin
                seen_bad = 1'b1;
            end
            step();
        end
        check("mc_quiet_busy", 64'(seen_bad),  64'd0);
        check("mc_valid",      64'(rsp_valid), 64'd1);
        check("mc_err",        64'(rsp_err),   64'd0);
        check("mc_sel",        64'(mux_sel),   64'd0);
        unit_done = 8'd0;
        step();
        check("mc_idle", 64'(req_ready), 64'd1);

        // Done honoured in the start cycle
        accept(3'd1, 32'd5, 32'd6);
        unit_done = 8'b0000_0010;
        check("mc0_start", 64'(unit_start), 64'h02);
        step();
        unit_done = 8'd0;
        check("mc0_valid", 64'(rsp_valid), 64'd1);
        check("mc0_err",   64'(rsp_err),   64'd0);
        step();

        // Timeout: op 1, done never asserted
        accept(3'd1, 32'h1111_1111, 32'h2222_2222);
        seen_bad = 1'b0;
        for (int c = 1; c <= 64; c++) begin
            if (rsp_valid !== 1'b0) seen_bad = 1'b1;
            step();
        end
        check("to_no_early_rsp", 64'(seen_bad),  64'd0);
        check("to_valid",        64'(rsp_valid), 64'd1);
        check("to_err",          64'(rsp_err),   64'd1);
        step();
        check("to_idle", 64'(req_ready), 64'd1);

        // Done coincides with the timeout cycle: done wins
        accept(3'd1, 32'h3333_3333, 32'h4444_4444);
        for (int c = 1; c <= 64; c++) begin
            unit_done = (c == 64) ? 8'b0000_0010 : 8'b0000_0000;
            step();
        end
        unit_done = 8'd0;
        check("tod_valid", 64'(rsp_valid), 64'd1);
        check("tod_err",   64'(rsp_err),   64'd0);
        step();

        // Backpressure: response held, new request refused
        rsp_ready = 1'b0;
        accept(3'd2, 32'h0000_00AA, 32'h0000_00BB);
        step();
        seen_bad = 1'b0;
        req_valid = 1'b1;
        req_op    = 3'd5;
        req_a     = 32'h5555_5555;
        req_b     = 32'h6666_6666;
        for (int c = 0; c < 10; c++) begin
            if (rsp_valid !== 1'b1 || req_ready !== 1'b0) seen_bad = 1'b1;
            step();
        end
        check("bp_held",    64'(seen_bad),  64'd0);
        check("bp_sel",     64'(mux_sel),   64'd2);
        check("bp_unit_a",  64'(unit_a),    64'h0000_00AA);
        check("bp_unit_b",  64'(unit_b),    64'h0000_00BB);
        check("bp_no_start", 64'(unit_start), 64'd0);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        step();
        check("bp_release_valid", 64'(rsp_valid), 64'd0);
        check("bp_release_ready", 64'(req_ready), 64'd1);

        // Reset during BUSY aborts with no response
        accept(3'd0, 32'h7777_7777, 32'h8888_8888);
        step();
        rst_n = 1'b0;
        #1;
        check("rb_ready",   64'(req_ready), 64'd1);
        check("rb_unit_a",  64'(unit_a),    64'd0);
        check("rb_mux_sel", 64'(mux_sel),   64'd0);
        check("rb_valid",   64'(rsp_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_bad = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (rsp_valid !== 1'b0 || req_ready !== 1'b1) seen_bad = 1'b1;
            step();
        end
        check("rb_no_rsp", 64'(seen_bad), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
